// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit.
// Turns the EX/MEM load/store into one valid/ready bus transaction. It formats the
// load data and the store byte lanes, and holds mem_stall until the access is done.
// Optional build macro MEM_LSU_MISALIGN_TRAP_EN: misaligned H/W accesses complete
// at once with mem_misalign=1 and no bus request.
// When the macro is absent, they go out on the bus with truncated lanes.
//
// state | meaning
// IDLE  | no access in flight, waiting for a load/store
// REQ   | bus_req_valid high, waiting for bus_req_ready
// WAIT  | request accepted, waiting for bus_rsp_valid or timeout
// DONE  | result valid for one cycle, stall released

module mem_lsu #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    input  logic            mem_ren,
    input  logic            mem_wen,
    input  logic [2:0]      mem_funct3,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_wdata,
    output logic            mem_stall,
    output logic [XLEN-1:0] mem_rdata,
    output logic            mem_err,
    output logic            mem_misalign,
    output logic            bus_req_valid,
    input  logic            bus_req_ready,
    output logic [XLEN-1:0] bus_addr,
    output logic            bus_wen,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_wmask,
    input  logic            bus_rsp_valid,
    input  logic [XLEN-1:0] bus_rsp_rdata,
    input  logic            bus_rsp_err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic            op;
    logic            trap_c;
    logic [1:0]      ofs;
    logic [4:0]      sh;
    logic [3:0]      wmask_c;
    logic [XLEN-1:0] wdata_c;
    logic            ld_is_load;
    logic [2:0]      ld_funct3;
    logic [1:0]      ld_ofs;
    logic [XLEN-1:0] rsp_shifted;
    logic [XLEN-1:0] load_fmt;

    assign op        = mem_valid & (mem_ren | mem_wen);
    assign mem_stall = op & (state != DONE);
    assign ofs       = mem_addr[1:0];
    assign sh        = {ofs, 3'b000};
    assign wdata_c   = mem_wdata << sh;

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    logic misalign_q;

    assign trap_c = ((mem_funct3[1:0] == 2'b01) & ofs[0]) |
                    ((mem_funct3[1:0] == 2'b10) & (ofs != 2'b00));
    assign mem_misalign = misalign_q;

    // Misalign flag is raised on the trap shortcut and dropped when DONE retires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (state == IDLE && op && trap_c) begin
            misalign_q <= 1'b1;
        end else if (state == DONE) begin
            misalign_q <= 1'b0;
        end
    end
`else
    assign trap_c       = 1'b0;
    assign mem_misalign = 1'b0;
`endif

    // Byte-lane strobes for the store size; lanes shifted past byte 3 are dropped
    always_comb begin
        case (mem_funct3[1:0])
            2'b00:   wmask_c = 4'b0001 << ofs;
            2'b01:   wmask_c = 4'b0011 << ofs;
            default: wmask_c = 4'b1111;
        endcase
    end

    // Load formatting uses the size and offset latched at request time, so a flush cannot disturb it
    always_comb begin
        rsp_shifted = bus_rsp_rdata >> {ld_ofs, 3'b000};
        case (ld_funct3)
            3'b000:  load_fmt = {{(XLEN-8){rsp_shifted[7]}}, rsp_shifted[7:0]};
            3'b001:  load_fmt = {{(XLEN-16){rsp_shifted[15]}}, rsp_shifted[15:0]};
            3'b100:  load_fmt = {{(XLEN-8){1'b0}}, rsp_shifted[7:0]};
            3'b101:  load_fmt = {{(XLEN-16){1'b0}}, rsp_shifted[15:0]};
            default: load_fmt = bus_rsp_rdata;
        endcase
    end

    // Access sequencer: one bus transaction per load/store, registered bus and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            mem_rdata     <= '0;
            mem_err       <= 1'b0;
            bus_req_valid <= 1'b0;
            bus_addr      <= '0;
            bus_wen       <= 1'b0;
            bus_wdata     <= '0;
            bus_wmask     <= 4'b0000;
            ld_is_load    <= 1'b0;
            ld_funct3     <= 3'b000;
            ld_ofs        <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (op && trap_c) begin
                        state   <= DONE;
                        mem_err <= 1'b0;
                    end else if (op) begin
                        state         <= REQ;
                        wait_cnt      <= '0;
                        bus_req_valid <= 1'b1;
                        bus_addr      <= {mem_addr[XLEN-1:2], 2'b00};
                        bus_wen       <= mem_wen;
                        bus_wdata     <= mem_wen ? wdata_c : '0;
                        bus_wmask     <= mem_wen ? wmask_c : 4'b0000;
                        ld_is_load    <= mem_ren;
                        ld_funct3     <= mem_funct3;
                        ld_ofs        <= ofs;
                    end
                end
                REQ: begin
                    if (bus_req_ready) begin
                        state         <= WAIT;
                        bus_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus_rsp_valid) begin
                        state   <= DONE;
                        mem_err <= bus_rsp_err;
                        if (ld_is_load) begin
                            mem_rdata <= load_fmt;
                        end
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        state   <= DONE;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    mem_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: randomized bench for mem_lsu with a transaction-level reference model.
// Build macro MEM_LSU_MISALIGN_TRAP_EN selects the trap expectations, as in the design.

module tb_mem_lsu;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_ren;
    logic        mem_wen;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_stall;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        mem_misalign;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_wen;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wmask;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;
    logic        bus_rsp_err;

    mem_lsu #(.XLEN(32), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_valid     (mem_valid),
        .mem_ren       (mem_ren),
        .mem_wen       (mem_wen),
        .mem_funct3    (mem_funct3),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_stall     (mem_stall),
        .mem_rdata     (mem_rdata),
        .mem_err       (mem_err),
        .mem_misalign  (mem_misalign),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_addr      (bus_addr),
        .bus_wen       (bus_wen),
        .bus_wdata     (bus_wdata),
        .bus_wmask     (bus_wmask),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_rdata (bus_rsp_rdata),
        .bus_rsp_err   (bus_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expectations for the current cycle, written by the driver
    logic        chk_en;
    logic        exp_stall, exp_reqv, exp_done, exp_wen, exp_err, exp_mis;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_wmask;
    logic        lit_valid;
    string       lit_name;
    logic [31:0] lit_act, lit_exp;

    // written only by the compare process
    int          n_checks, n_errors, n_stall, n_reqv;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_wmask;

    // snapshot of result outputs taken in DONE
    logic        dn_err, dn_mis;
    int          s0, r0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: checks every output against the model once per cycle
    always @(negedge clk) begin
        if (lit_valid) chk(lit_name, lit_act, lit_exp);
        if (chk_en) begin
            if (mem_stall) n_stall++;
            if (bus_req_valid) begin
                n_reqv++;
                last_addr  = bus_addr;
                last_wdata = bus_wdata;
                last_wmask = bus_wmask;
            end
            chk("mem_stall", {31'b0, mem_stall}, {31'b0, exp_stall});
            chk("bus_req_valid", {31'b0, bus_req_valid}, {31'b0, exp_reqv});
            chk("mem_rdata", mem_rdata, exp_rdata);
            if (exp_reqv) begin
                chk("bus_addr", bus_addr, exp_addr);
                chk("bus_wen", {31'b0, bus_wen}, {31'b0, exp_wen});
                if (exp_wen) begin
                    chk("bus_wdata", bus_wdata, exp_wdata);
                    chk("bus_wmask", {28'b0, bus_wmask}, {28'b0, exp_wmask});
                end
            end
            if (exp_done) begin
                chk("mem_err", {31'b0, mem_err}, {31'b0, exp_err});
                chk("mem_misalign", {31'b0, mem_misalign}, {31'b0, exp_mis});
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_load(input logic [2:0] f3, input int ofs, input logic [31:0] w);
        int b[4];
        int v;
        for (int i = 0; i < 4; i++) b[i] = int'((w >> (8 * i)) & 32'hFF);
        case (f3)
            3'b000: begin v = b[ofs]; if (v >= 128) v = v - 256; end
            3'b100: v = b[ofs];
            3'b001, 3'b101: begin
                v = b[ofs] + 256 * ((ofs < 3) ? b[(ofs + 1) % 4] : 0);
                if (f3 == 3'b001 && v >= 32768) v = v - 65536;
            end
            default: return w;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [3:0] model_mask(input logic [2:0] f3, input int ofs);
        int size;
        logic [3:0] m;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        m = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (size == 4 || (i >= ofs && i < ofs + size)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input int ofs);
        logic [31:0] d;
        d = 32'h0;
        for (int i = 0; i < 4; i++)
            if (i >= ofs) d = d | (((wd >> (8 * (i - ofs))) & 32'hFF) << (8 * i));
        return d;
    endfunction

    function automatic bit model_trap(input logic [2:0] f3, input int ofs);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        return (f3[1:0] == 2'b01 && (ofs % 2) == 1) || (f3[1:0] == 2'b10 && ofs != 0);
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
        lit_valid = 1'b0;
    endtask

    task automatic set_lit(input string n, input logic [31:0] a, input logic [31:0] e);
        lit_name  = n;
        lit_act   = a;
        lit_exp   = e;
        lit_valid = 1'b1;
    endtask

    task automatic garbage_rsp();
        bus_rsp_valid = (($urandom % 3) == 0);
        bus_rsp_rdata = $urandom;
        bus_rsp_err   = $urandom % 2;
    endtask

    task automatic idle_cyc(input bit late);
        mem_valid     = $urandom % 2;
        mem_ren       = 1'b0;
        mem_wen       = 1'b0;
        mem_funct3    = $urandom % 8;
        mem_addr      = $urandom;
        bus_req_ready = $urandom % 2;
        garbage_rsp();
        if (late) bus_rsp_valid = 1'b1;
        exp_stall = 1'b0;
        exp_reqv  = 1'b0;
        exp_done  = 1'b0;
        step();
    endtask

    // one load/store: rd = cycles ready stays low, rsp_d = WAIT cycle of the response (>= TO: none)
    task automatic do_op(input bit ren, input bit wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int rd, input int rsp_d,
                         input logic [31:0] rsp_data, input bit rsp_err, input bit flush, input bit late);
        int ofs, w;
        ofs = int'(addr % 4);
        mem_valid     = 1'b1;
        mem_ren       = ren;
        mem_wen       = wen;
        mem_funct3    = f3;
        mem_addr      = addr;
        mem_wdata     = wdata;
        bus_req_ready = $urandom % 2;
        garbage_rsp();
        exp_stall = 1'b1;
        exp_reqv  = 1'b0;
        exp_done  = 1'b0;
        step();
        if (model_trap(f3, ofs)) begin
            garbage_rsp();
            exp_stall = 1'b0;
            exp_done  = 1'b1;
            exp_err   = 1'b0;
            exp_mis   = 1'b1;
            dn_err    = mem_err;
            dn_mis    = mem_misalign;
            step();
            return;
        end
        exp_addr  = addr & 32'hFFFF_FFFC;
        exp_wen   = wen;
        exp_wdata = model_wdata(wdata, ofs);
        exp_wmask = model_mask(f3, ofs);
        for (int j = 0; j <= rd; j++) begin
            bus_req_ready = (j == rd);
            garbage_rsp();
            if (flush) mem_valid = 1'b0;
            exp_stall = mem_valid;
            exp_reqv  = 1'b1;
            step();
        end
        w = (rsp_d < TO) ? rsp_d + 1 : TO;
        for (int k = 0; k < w; k++) begin
            bus_req_ready = $urandom % 2;
            bus_rsp_valid = (k == rsp_d);
            bus_rsp_rdata = (k == rsp_d) ? rsp_data : $urandom;
            bus_rsp_err   = (k == rsp_d) ? rsp_err : 1'($urandom % 2);
            exp_reqv  = 1'b0;
            exp_stall = mem_valid;
            step();
        end
        if (rsp_d < TO) begin
            exp_err = rsp_err;
            if (ren) exp_rdata = model_load(f3, ofs, rsp_data);
        end else begin
            exp_err = 1'b1;
        end
        exp_mis = 1'b0;
        garbage_rsp();
        if (late) bus_rsp_valid = 1'b1;
        exp_stall = 1'b0;
        exp_done  = 1'b1;
        dn_err    = mem_err;
        dn_mis    = mem_misalign;
        step();
    endtask

    // async reset in REQ (in_wait=0) or WAIT (in_wait=1) with a response arriving afterwards
    task automatic reset_mid(input bit in_wait);
        chk_en        = 1'b0;
        mem_valid     = 1'b1;
        mem_ren       = 1'b1;
        mem_wen       = 1'b0;
        mem_funct3    = 3'b010;
        mem_addr      = 32'h3000;
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        step();
        if (in_wait) begin
            bus_req_ready = 1'b1;
            step();
            bus_req_ready = 1'b0;
            step();
        end
        #1 rst = 1'b1;
        #1;
        set_lit("rst_req_valid", {31'b0, bus_req_valid}, 32'd0);
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'h5A5A_5A5A;
        bus_rsp_err   = 1'b1;
        step();
        set_lit("rst_stall_idle", {31'b0, mem_stall}, 32'd1);
        step();
        set_lit("rst_rdata_clear", mem_rdata, 32'd0);
        mem_valid = 1'b0;
        #1 rst = 1'b0;
        step();
        set_lit("rst_err_clear", {31'b0, mem_err}, 32'd0);
        bus_rsp_valid = 1'b0;
        exp_rdata = 32'h0;
        exp_stall = 1'b0;
        exp_reqv  = 1'b0;
        exp_done  = 1'b0;
        chk_en    = 1'b1;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    logic [2:0] ld_tab [5];
    bit         r_ren;
    logic [2:0] r_f3;
    int         r_sel, r_rspd;

    initial begin
        ld_tab[0] = 3'b000; ld_tab[1] = 3'b001; ld_tab[2] = 3'b010;
        ld_tab[3] = 3'b100; ld_tab[4] = 3'b101;
        n_checks = 0; n_errors = 0; n_stall = 0; n_reqv = 0;
        rst = 1'b1;
        chk_en = 1'b0; lit_valid = 1'b0;
        mem_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; mem_funct3 = 3'b000;
        mem_addr = 32'h0; mem_wdata = 32'h0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'h0; bus_rsp_err = 1'b0;
        exp_stall = 1'b0; exp_reqv = 1'b0; exp_done = 1'b0; exp_wen = 1'b0;
        exp_err = 1'b0; exp_mis = 1'b0; exp_addr = 32'h0; exp_wdata = 32'h0;
        exp_rdata = 32'h0; exp_wmask = 4'h0;
        step();

        // reset state
        set_lit("reset_req_valid", {31'b0, bus_req_valid}, 32'd0); step();
        set_lit("reset_rdata", mem_rdata, 32'd0);                   step();
        set_lit("reset_err", {31'b0, mem_err}, 32'd0);              step();
        set_lit("reset_misalign", {31'b0, mem_misalign}, 32'd0);    step();
        set_lit("reset_stall", {31'b0, mem_stall}, 32'd0);          step();
        set_lit("reset_bus_addr", bus_addr, 32'd0);                 step();
        set_lit("reset_bus_wmask", {28'b0, bus_wmask}, 32'd0);      step();
        set_lit("reset_bus_wen", {31'b0, bus_wen}, 32'd0);          step();
        rst = 1'b0;
        chk_en = 1'b1;
        idle_cyc(0);

        // LW, minimum latency
        s0 = n_stall;
        do_op(1, 0, 3'b010, 32'h1000, 32'h0, 0, 0, 32'hDEAD_BEEF, 0, 0, 0);
        set_lit("lw_stall_cycles", 32'(n_stall - s0), 32'd3); idle_cyc(0);
        set_lit("lw_rdata", mem_rdata, 32'hDEAD_BEEF);         idle_cyc(0);
        set_lit("lw_err", {31'b0, dn_err}, 32'd0);             idle_cyc(0);

        // byte / half formatting
        do_op(1, 0, 3'b000, 32'h1003, 32'h0, 0, 0, 32'h8011_2233, 0, 0, 0);
        set_lit("lb_rdata", mem_rdata, 32'hFFFF_FF80);  idle_cyc(0);
        do_op(1, 0, 3'b100, 32'h1003, 32'h0, 0, 0, 32'h8011_2233, 0, 0, 0);
        set_lit("lbu_rdata", mem_rdata, 32'h0000_0080); idle_cyc(0);
        do_op(1, 0, 3'b101, 32'h1002, 32'h0, 0, 0, 32'h8011_2233, 0, 0, 0);
        set_lit("lhu_rdata", mem_rdata, 32'h0000_8011); idle_cyc(0);

        // SH with ready held low 4 cycles
        r0 = n_reqv;
        do_op(0, 1, 3'b001, 32'h2002, 32'h0000_ABCD, 4, 0, 32'h1234_5678, 0, 0, 0);
        set_lit("sh_req_cycles", 32'(n_reqv - r0), 32'd5);     idle_cyc(0);
        set_lit("sh_wmask", {28'b0, last_wmask}, 32'hC);        idle_cyc(0);
        set_lit("sh_wdata", last_wdata, 32'hABCD_0000);         idle_cyc(0);
        set_lit("sh_addr", last_addr, 32'h0000_2000);           idle_cyc(0);
        set_lit("sh_rdata_kept", mem_rdata, 32'h0000_8011);     idle_cyc(0);

        // LW timeout, then late responses
        s0 = n_stall;
        do_op(1, 0, 3'b010, 32'h1000, 32'h0, 0, TO, 32'h0, 0, 0, 1);
        set_lit("to_stall_cycles", 32'(n_stall - s0), 32'(2 + TO)); idle_cyc(1);
        set_lit("to_err", {31'b0, dn_err}, 32'd1);                  idle_cyc(1);
        set_lit("to_rdata_kept", mem_rdata, 32'h0000_8011);         idle_cyc(0);

        // misaligned LW
        s0 = n_stall;
        r0 = n_reqv;
        do_op(1, 0, 3'b010, 32'h1001, 32'h0, 0, 0, 32'h1122_3344, 0, 0, 0);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        set_lit("mis_stall_cycles", 32'(n_stall - s0), 32'd1); idle_cyc(0);
        set_lit("mis_req_cycles", 32'(n_reqv - r0), 32'd0);    idle_cyc(0);
        set_lit("mis_flag", {31'b0, dn_mis}, 32'd1);           idle_cyc(0);
        set_lit("mis_rdata_kept", mem_rdata, 32'h0000_8011);   idle_cyc(0);
`else
        set_lit("mis_stall_cycles", 32'(n_stall - s0), 32'd3); idle_cyc(0);
        set_lit("mis_req_cycles", 32'(n_reqv - r0), 32'd1);    idle_cyc(0);
        set_lit("mis_flag", {31'b0, dn_mis}, 32'd0);           idle_cyc(0);
        set_lit("mis_rdata", mem_rdata, 32'h1122_3344);        idle_cyc(0);
`endif

        // async reset mid-operation
        reset_mid(0);
        idle_cyc(0);
        reset_mid(1);
        do_op(1, 0, 3'b010, 32'h4000, 32'h0, 0, 0, 32'hCAFE_F00D, 0, 0, 0);
        set_lit("post_rst_rdata", mem_rdata, 32'hCAFE_F00D); idle_cyc(0);

        // randomized traffic, with back-to-back ops, flushes, error and timeout responses
        for (int n = 0; n < 300; n++) begin
            r_ren = $urandom % 2;
            r_f3  = r_ren ? ld_tab[$urandom % 5] : 3'($urandom % 3);
            r_sel = $urandom % 10;
            r_rspd = (r_sel < 7) ? int'($urandom_range(0, 3)) :
                     (r_sel == 7) ? TO - 1 :
                     (r_sel == 8) ? int'($urandom_range(4, TO - 2)) : TO;
            do_op(r_ren, !r_ren, r_f3, $urandom, $urandom, int'($urandom_range(0, 3)), r_rspd,
                  $urandom, (($urandom % 8) == 0), (($urandom % 8) == 0), (($urandom % 2) == 0));
            for (int g = 0; g < int'($urandom % 3); g++) idle_cyc(0);
        end

        idle_cyc(0);
        idle_cyc(0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
